// File: rtl/seg_display_scheduler.sv
// Seven-segment display page scheduler: debounced page button plus a debug snapshot override.
// Optional auto-advance of the page when idle is built only with DISP_AUTOSCAN_EN defined.
module seg_display_scheduler #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned HOLD_CYCLES     = 64,
    parameter int unsigned SCAN_CYCLES     = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        button,
    input  logic [31:0] src0_data,
    input  logic [31:0] src1_data,
    input  logic [31:0] src2_data,
    input  logic [31:0] src3_data,
    input  logic        dbg_req,
    input  logic [31:0] dbg_data,
    output logic        dbg_ack,
    output logic [31:0] disp_data,
    output logic        disp_hi,
    output logic [2:0]  page,
    output logic        dbg_active
);

    // state | meaning
    // PAGE  | manual page shown, disp_data follows the selected source
    // DBG   | debug snapshot frozen on the display for HOLD_CYCLES cycles
    typedef enum logic {PAGE, DBG} state_t;

    localparam logic [15:0] DEB_LAST  = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES);
    localparam logic [15:0] CNT_MAX   = 16'hFFFF;

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535 ||
        HOLD_CYCLES < 1 || HOLD_CYCLES > 65535 ||
        SCAN_CYCLES < 1 || SCAN_CYCLES > 65535) begin : g_bad_param
        $error("seg_display_scheduler: cycle parameters must be in 1..65535");
    end

    state_t      state, state_next;
    logic        btn_meta, btn_sync;
    logic [15:0] deb_cnt;
    logic        press;
    logic [15:0] hold_cnt, hold_next;
    logic [2:0]  page_next;
    logic [31:0] disp_next;
    logic        ack_next;
    logic [31:0] src_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_meta <= 1'b0;
            btn_sync <= 1'b0;
            deb_cnt  <= '0;
        end else begin
            btn_meta <= button;
            btn_sync <= btn_meta;
            if (!btn_sync)
                deb_cnt <= '0;
            else if (deb_cnt != CNT_MAX)
                deb_cnt <= deb_cnt + 16'd1;
        end
    end

    // Fires only on the transition to DEBOUNCE_CYCLES; a held button saturates past it.
    assign press = btn_sync && (deb_cnt == DEB_LAST);

    always_comb begin
        case (page[2:1])
            2'd0:    src_sel = src0_data;
            2'd1:    src_sel = src1_data;
            2'd2:    src_sel = src2_data;
            default: src_sel = src3_data;
        endcase
    end

`ifdef DISP_AUTOSCAN_EN
    localparam logic [15:0] SCAN_LAST = 16'(SCAN_CYCLES - 1);
    logic [15:0] scan_cnt, scan_next;
    logic        scan_due;

    assign scan_due = (scan_cnt == SCAN_LAST);

    always_comb begin
        scan_next = scan_cnt;
        if (state != PAGE || dbg_req || press || scan_due)
            scan_next = '0;
        else if (scan_cnt != CNT_MAX)
            scan_next = scan_cnt + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) scan_cnt <= '0;
        else        scan_cnt <= scan_next;
    end
`else
    logic scan_due;
    assign scan_due = 1'b0;
`endif

    always_comb begin
        state_next = state;
        page_next  = page;
        disp_next  = disp_data;
        ack_next   = 1'b0;
        hold_next  = hold_cnt;
        case (state)
            PAGE: begin
                disp_next = src_sel;
                hold_next = '0;
                if (dbg_req) begin
                    state_next = DBG;
                    ack_next   = 1'b1;
                end else if (press || scan_due) begin
                    page_next = page + 3'd1;
                end
            end
            default: begin
                // Snapshot is taken at the end of the ack cycle, then frozen.
                if (dbg_ack)
                    disp_next = dbg_data;
                if (hold_cnt == HOLD_LAST) begin
                    state_next = PAGE;
                    disp_next  = src_sel;
                end else if (hold_cnt != CNT_MAX) begin
                    hold_next = hold_cnt + 16'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= PAGE;
            page      <= '0;
            disp_data <= '0;
            dbg_ack   <= 1'b0;
            hold_cnt  <= '0;
        end else begin
            state     <= state_next;
            page      <= page_next;
            disp_data <= disp_next;
            dbg_ack   <= ack_next;
            hold_cnt  <= hold_next;
        end
    end

    assign dbg_active = (state == DBG);
    assign disp_hi    = (state == DBG) ? 1'b0 : page[0];

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Bench for seg_display_scheduler: cycle model compared every cycle plus directed literal checks.
// Build with DISP_AUTOSCAN_EN defined to exercise the auto-advance variant.
module tb_seg_display_scheduler;

    localparam int D = 16;
    localparam int H = 64;
    localparam int S = 8;
`ifdef DISP_AUTOSCAN_EN
    localparam bit AUTOSCAN = 1'b1;
    localparam int IDLE_PAGE = 3;
`else
    localparam bit AUTOSCAN = 1'b0;
    localparam int IDLE_PAGE = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        button = 1'b0;
    logic [31:0] src0_data = 32'h1234_5678;
    logic [31:0] src1_data = 32'h89AB_CDEF;
    logic [31:0] src2_data = 32'h0F0F_F0F0;
    logic [31:0] src3_data = 32'h5555_AAAA;
    logic        dbg_req = 1'b0;
    logic [31:0] dbg_data = 32'h0;
    logic        dbg_ack;
    logic [31:0] disp_data;
    logic        disp_hi;
    logic [2:0]  page;
    logic        dbg_active;

    int n_total = 0;
    int n_pass  = 0;

    seg_display_scheduler #(
        .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .SCAN_CYCLES(S)
    ) dut (
        .clk(clk), .rst_n(rst_n), .button(button),
        .src0_data(src0_data), .src1_data(src1_data),
        .src2_data(src2_data), .src3_data(src3_data),
        .dbg_req(dbg_req), .dbg_data(dbg_data), .dbg_ack(dbg_ack),
        .disp_data(disp_data), .disp_hi(disp_hi), .page(page),
        .dbg_active(dbg_active)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] src_of(input int p);
        case (p / 2)
            0:       return src0_data;
            1:       return src1_data;
            2:       return src2_data;
            default: return src3_data;
        endcase
    endfunction

    // Model: m_left = cycles of snapshot display still to come (0 = manual page mode).
    logic [1:0]  m_sync;
    int          m_run, m_page, m_left, m_scan;
    logic [31:0] m_disp;

    always @(posedge clk or negedge rst_n) begin : model
        int run_n, page_n, left_n, scan_n;
        logic [31:0] disp_n;
        bit pressed;
        if (!rst_n) begin
            m_sync <= '0; m_run <= 0; m_page <= 0; m_left <= 0; m_scan <= 0; m_disp <= '0;
        end else begin
            run_n   = m_sync[1] ? ((m_run < 65535) ? m_run + 1 : 65535) : 0;
            pressed = m_sync[1] && (run_n == D) && (m_run != D);
            page_n = m_page; left_n = m_left; scan_n = m_scan; disp_n = m_disp;
            if (m_left > 0) begin
                if (m_left == H + 1) disp_n = dbg_data;
                left_n = m_left - 1;
                if (left_n == 0) disp_n = src_of(m_page);
                scan_n = 0;
            end else begin
                disp_n = src_of(m_page);
                if (dbg_req) begin
                    left_n = H + 1;
                    scan_n = 0;
                end else if (pressed) begin
                    page_n = (m_page + 1) % 8;
                    scan_n = 0;
                end else if (AUTOSCAN) begin
                    scan_n = m_scan + 1;
                    if (scan_n == S) begin
                        page_n = (m_page + 1) % 8;
                        scan_n = 0;
                    end
                end
            end
            m_sync <= {m_sync[0], button};
            m_run  <= run_n;
            m_page <= page_n;
            m_left <= left_n;
            m_scan <= scan_n;
            m_disp <= disp_n;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("cyc_page", 32'(page), 32'(m_page));
            check("cyc_disp_data", disp_data, m_disp);
            check("cyc_disp_hi", 32'(disp_hi), (m_left > 0) ? 32'd0 : 32'(m_page % 2));
            check("cyc_dbg_ack", 32'(dbg_ack), 32'(m_left == H + 1));
            check("cyc_dbg_active", 32'(dbg_active), 32'(m_left > 0));
        end
    end

    task automatic push(input int n);
        button = 1'b1;
        repeat (n) @(negedge clk);
        button = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    logic [31:0] page_tab [8];
    int acks, snaps;

    initial begin
        page_tab = '{32'h1234_5678, 32'h1234_5678, 32'h89AB_CDEF, 32'h89AB_CDEF,
                     32'h0F0F_F0F0, 32'h0F0F_F0F0, 32'h5555_AAAA, 32'h5555_AAAA};
        repeat (3) @(negedge clk);
        check("rst_disp_data", disp_data, 32'h0);
        check("rst_page", 32'(page), 32'd0);
        check("rst_dbg_ack", 32'(dbg_ack), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("rel_disp_data", disp_data, 32'h1234_5678);
        check("rel_page", 32'(page), 32'd0);
        check("rel_disp_hi", 32'(disp_hi), 32'd0);
        repeat (22) @(negedge clk);
        check("idle_page", 32'(page), 32'(IDLE_PAGE));

`ifndef DISP_AUTOSCAN_EN
        push(15);
        check("deb15_page", 32'(page), 32'd0);
        push(20);
        check("deb16_page", 32'(page), 32'd1);
        check("deb16_disp_hi", 32'(disp_hi), 32'd1);
        check("deb16_disp_data", disp_data, 32'h1234_5678);

        for (int k = 0; k < 8; k++) begin
            push(20);
            check("wrap_page", 32'(page), 32'((k + 2) % 8));
            check("wrap_disp_data", disp_data, page_tab[(k + 2) % 8]);
        end
        push(20);
        push(20);
        check("pre_dbg_page", 32'(page), 32'd3);

        dbg_data = 32'hDEAD_BEEF;
        dbg_req  = 1'b1;
        @(negedge clk);
        dbg_req = 1'b0;
        check("dbg_ack_first", 32'(dbg_ack), 32'd1);
        check("dbg_active_first", 32'(dbg_active), 32'd1);
        acks = 1; snaps = 0;
        for (int i = 0; i < 80; i++) begin
            if (i == 10) button = 1'b1;
            if (i == 30) button = 1'b0;
            @(negedge clk);
            acks  += int'(dbg_ack);
            snaps += int'(disp_data == 32'hDEAD_BEEF);
        end
        check("dbg_ack_count", 32'(acks), 32'd1);
        check("dbg_hold_cycles", 32'(snaps), 32'd64);
        check("dbg_ret_page", 32'(page), 32'd3);
        check("dbg_ret_disp", disp_data, 32'h89AB_CDEF);
        check("dbg_ret_hi", 32'(disp_hi), 32'd1);

        dbg_data = 32'hCAFE_0001;
        button   = 1'b1;
        repeat (17) @(negedge clk);
        dbg_req = 1'b1;
        @(negedge clk);
        dbg_req = 1'b0;
        check("tie_ack", 32'(dbg_ack), 32'd1);
        repeat (2) @(negedge clk);
        button = 1'b0;
        repeat (80) @(negedge clk);
        check("tie_page", 32'(page), 32'd3);
        check("tie_disp", disp_data, 32'h89AB_CDEF);

        dbg_req = 1'b1;
        acks = 0;
        repeat (100) begin
            @(negedge clk);
            acks += int'(dbg_ack);
        end
        dbg_req = 1'b0;
        check("held_req_acks", 32'(acks), 32'd2);
        repeat (40) @(negedge clk);
        check("held_req_page", 32'(page), 32'd3);
`else
        push(20);
        dbg_data = 32'hDEAD_BEEF;
        dbg_req  = 1'b1;
        @(negedge clk);
        dbg_req = 1'b0;
        repeat (90) @(negedge clk);
`endif

        dbg_req = 1'b1;
        @(negedge clk);
        dbg_req = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rstdbg_active", 32'(dbg_active), 32'd0);
        check("rstdbg_page", 32'(page), 32'd0);
        check("rstdbg_ack", 32'(dbg_ack), 32'd0);
        check("rstdbg_disp", disp_data, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rstrel_page", 32'(page), 32'd0);
        check("rstrel_active", 32'(dbg_active), 32'd0);
        check("rstrel_disp", disp_data, 32'h1234_5678);
        repeat (5) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
